// File: rtl/sram_port0_ctrl_if.sv
// ============================================================================
//  Module      : sram_port0_ctrl_if
//  Description : Request/response handshake and macro pin bundle for port 0
//                (RW) of the 32x512 OpenRAM macro.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_port0_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    // Request channel (valid/ready)
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    // Response channel (valid/ready), read data only
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // Macro port 0 pins
    logic                  sram_csb0;
    logic                  sram_web0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0;

    // Requester / macro side
    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        output rsp_ready,
        output sram_dout0,
        input  req_ready,
        input  rsp_valid, rsp_rdata,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  rsp_ready,
        input  sram_dout0,
        output req_ready,
        output rsp_valid, rsp_rdata,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0
    );
endinterface

`default_nettype wire

// File: rtl/sram_port0_ctrl.sv
// ============================================================================
//  Module      : sram_port0_ctrl
//  Description : Valid/ready front-end for port 0 of the 32x512 OpenRAM macro.
//                Drives the active-low macro pins combinationally from the
//                accepted request, captures read data one cycle after the
//                macro's negedge read and returns it in order through a small
//                response FIFO with backpressure. Writes produce no response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port0_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 3     // legal range 2..8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sram_port0_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Derived sizes. Storage is rounded up to a power of two so any pointer
    // value indexes a real slot; pointers still wrap at RSP_DEPTH-1.
    // ------------------------------------------------------------------------
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int SLOTS = 1 << PTR_W;

    localparam logic [PTR_W-1:0] c_ptr_last  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [OCC_W-1:0] c_occ_limit = OCC_W'(RSP_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  r_rd_pending;   // read issued last edge, data due now
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_mem [SLOTS];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_acc;
    logic             w_req_ready;
    logic [OCC_W-1:0] w_occ;
    logic             w_push;
    logic             w_pop;
    logic             w_rsp_valid;

    // Occupancy counts the read still in the macro pipeline as well as the
    // FIFO contents, so an accepted read always has a slot waiting for it.
    // Writes are gated by the same rule to keep strict ordering.
    assign w_occ       = OCC_W'(r_count) + OCC_W'(r_rd_pending);
    assign w_req_ready = ~rst & (w_occ < c_occ_limit);
    assign w_acc       = bus.req_valid & w_req_ready;

    assign w_rsp_valid = (r_count != '0);
    assign w_push      = r_rd_pending;
    assign w_pop       = w_rsp_valid & bus.rsp_ready;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready   = w_req_ready;

    // Macro pins follow the accepted request in the same cycle; the macro
    // samples them on the coming posedge. Idle values are all-zero data.
    assign bus.sram_csb0   = ~w_acc;
    assign bus.sram_web0   = ~(w_acc & bus.req_we);
    assign bus.sram_addr0  = w_acc ? bus.req_addr  : '0;
    assign bus.sram_din0   = w_acc ? bus.req_wdata : '0;
    assign bus.sram_wmask0 = w_acc ? bus.req_wmask : '0;

    // Read data is forced to zero when nothing is queued so the output is
    // clean after reset and between responses; it is held while stalled.
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_rdata   = w_rsp_valid ? r_mem[r_rd_ptr] : '0;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Flag a read accepted this edge; its data appears on dout0 after the
    // following negedge and is pushed on the next posedge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= w_acc & ~bus.req_we;
        end
    end

    // Write pointer advances on each captured read, wrapping at the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on each consumed response, wrapping at the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Entry count; simultaneous push and pop leave it unchanged. Overflow
    // cannot occur because acceptance already reserved the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response storage: capture the macro's read data into the write slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.sram_dout0;
        end
    end

endmodule

`default_nettype wire

// File: doc/sram_port0_ctrl.md
# sram_port0_ctrl

Valid/ready front-end for port 0 (RW) of the 32x512 OpenRAM macro. Upstream masters issue read/write requests, and the block drives the macro's active-low control pins. Read data is captured on the cycle after the macro's negedge read and returned through an in-order response FIFO with backpressure. Writes produce no response.

## Interface
- ADDR_WIDTH, 9, word address width (matches macro)
- DATA_WIDTH, 32, data width
- NUM_WMASKS, 4, byte-enable count (DATA_WIDTH/8)
- RSP_DEPTH, 3, response FIFO entries; legal range 2..8
- clk  in  1  single clock; also drives macro clk0 externally
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready at posedge
- req_we  in  1  1 = write, 0 = read
- req_wmask  in  NUM_WMASKS  byte enables (writes only)
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes data
- rsp_rdata  out  DATA_WIDTH  read data, in request order
- sram_csb0  out  1  macro chip select, active low
- sram_web0  out  1  macro write enable, active low
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro read data

## Operation
- Accept condition: `acc = req_valid & req_ready`.
- Macro pins are combinational from the request:
  - `sram_csb0 = ~acc`
  - `sram_web0 = ~(acc & req_we)`
  - `sram_addr0`, `sram_din0` and `sram_wmask0` equal the req fields when acc, else all zeros.
- Occupancy `occ = fifo_count + rd_pending`. `req_ready = ~rst & (occ < RSP_DEPTH)`. This rule is independent of req_we, so a stalled read response also stalls later writes and strict ordering is preserved.
- `rd_pending` (1 bit) is set at the posedge where a read is accepted and cleared otherwise. When set, that edge's sram_dout0 is pushed into the FIFO at the next posedge.
- FIFO: circular buffer with wrapping read/write pointers and a count.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop occurs when `rsp_valid & rsp_ready`.
  - Push never occurs when the FIFO is full; the occ check guarantees this.
- A write with wmask = 0 is still accepted and still issued with csb0 = 0 and web0 = 0; memory is unchanged.
- Reset (async, at any time):
  - Clears rd_pending, the FIFO pointers, the count and the storage.
  - Any in-flight read is discarded.

## Timing
- Reset values: req_ready = 0 while rst = 1, and 1 in the first cycle after release. rsp_valid = 0, rsp_rdata = 0, sram_csb0 = 1, sram_web0 = 1, and the remaining sram_* outputs = 0.
- Read latency:
  - Read accepted at edge E_N; the macro samples at E_N and updates dout0 at the next negedge.
  - Data is captured at E_N+1.
  - rsp_valid = 1 in the cycle after E_N+1, i.e. 2 cycles from accept.
- Throughput: with RSP_DEPTH ≥ 3 and rsp_ready held at 1, one read is accepted per cycle indefinitely. With RSP_DEPTH = 2, at most 2 reads are accepted in every 3 cycles.
- Write then read to the same address on consecutive cycles returns the new data. The macro's write completes at the negedge before the read is sampled, so no forwarding is needed.
- rsp_rdata is stable while `rsp_valid & ~rsp_ready`.

## Test plan
- Reset/idle:
  - Assert rst mid-cycle → req_ready, rsp_valid and sram_web0 go to 0, 0, 1 immediately; sram_csb0 = 1.
  - Release → req_ready = 1 on the next cycle.
- Write then read:
  - Write addr 0x005, data 0xDEADBEEF, wmask 0xF.
  - Next cycle, read 0x005 → rsp_rdata = 0xDEADBEEF exactly 2 cycles after the read is accepted.
- Byte mask:
  - Write 0x11223344 to addr 0x1FF with wmask 0xF.
  - Then write 0xAABBCCDD with wmask 0x5.
  - Read addr 0x1FF → 0x11BB33DD.
- Streaming:
  - 8 back-to-back reads of addrs 0..7, rsp_ready = 1.
  - Required: req_ready stays 1 throughout.
  - Required: responses appear on 8 consecutive cycles, in order.
- Backpressure:
  - Hold rsp_ready = 0 and issue 5 reads.
  - Required: exactly 3 reads are accepted, then req_ready = 0, and rsp_rdata holds the first datum.
  - Raise rsp_ready → the remaining 2 reads are accepted and all 5 responses arrive in order.
- Reset mid-flight:
  - Accept a read, then assert rst the next cycle.
  - Required: no response is ever produced, occupancy = 0 after release, and req_ready = 1.
